// File: rtl/ser_deser_rx_pkg.sv
// Shared types for the serial receive path and its matching transmit-side controller.
package ser_deser_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        PARITY   = 2'd2,
        COMPLETE = 2'd3
    } rx_state_t;

    function automatic int rx_cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/ser_deser_rx.sv
// Serial-to-parallel frame receiver: MSB-first bits in, SIZE-bit words out on a valid/ready port.
// Optional trailing even-parity bit when SER_DESER_RX_PARITY_EN is defined.
module ser_deser_rx
    import ser_deser_rx_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_bit_vld,
    input  logic            i_ser_in,
    input  logic            i_out_ready,
    input  logic            i_ovr_clr,
    output logic [SIZE-1:0] o_data_out,
    output logic            o_out_valid,
    output logic            o_parity_err,
    output logic            o_busy,
    output logic            o_overrun
);

    localparam int            CW      = rx_cnt_w(SIZE);
    localparam logic [CW-1:0] CNT_LST = CW'(SIZE - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(SIZE);

    rx_state_t       r_state;
    logic [SIZE-1:0] r_shift;
    logic [CW-1:0]   r_cnt;
    logic [SIZE-1:0] r_data_out;
    logic            r_out_valid;
    logic            r_overrun;

    logic            w_slot_free;
    logic [CW-1:0]   w_next_cnt;

    // A held word that is being accepted this cycle frees the slot for an immediate refill.
    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_next_cnt  = (r_cnt == CNT_SAT) ? CNT_SAT : r_cnt + 1'b1;

`ifdef SER_DESER_RX_PARITY_EN
    logic r_perr_pend;
    logic r_parity_err;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SER_DESER_RX_PARITY_EN
            r_perr_pend  <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;

            // Clear first so a same-cycle overrun below takes priority.
            if (i_ovr_clr)
                r_overrun <= 1'b0;

            if (r_state == COMPLETE) begin
                if (w_slot_free) begin
                    r_data_out  <= r_shift;
                    r_out_valid <= 1'b1;
`ifdef SER_DESER_RX_PARITY_EN
                    r_parity_err <= r_perr_pend;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (i_start) begin
                r_state <= SHIFT;
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    SHIFT: begin
                        if (i_bit_vld) begin
                            r_shift <= {r_shift[SIZE-2:0], i_ser_in};
                            r_cnt   <= w_next_cnt;
                            if (r_cnt == CNT_LST)
`ifdef SER_DESER_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= COMPLETE;
`endif
                        end
                    end
`ifdef SER_DESER_RX_PARITY_EN
                    PARITY: begin
                        if (i_bit_vld) begin
                            r_perr_pend <= (^r_shift) ^ i_ser_in;
                            r_state     <= COMPLETE;
                        end
                    end
`endif
                    COMPLETE: r_state <= IDLE;
                    default:  r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_data_out  = r_data_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;
`ifdef SER_DESER_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
